lcd_ram_write_arbiter: RTL and testbench



---
 rtl/lcd_ram_write_arbiter_pkg.sv | 27 ++
 rtl/lcd_ram_write_arbiter_if.sv | 55 +++++
 rtl/lcd_ram_write_arbiter_rr_arb2.sv | 42 ++++
 rtl/lcd_ram_write_arbiter.sv | 125 ++++++++++++
 tb/tb_lcd_ram_write_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_ram_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_pkg                                                       |
// | Purpose  : Shared constants and types for the LCD character-RAM write    |
// |            arbiter (geometry, blank character, FSM states, requester id).|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package lcd_pkg;

   localparam int          LCD_ADDR_W     = 5;
   localparam int          LCD_DATA_W     = 8;
   localparam logic [7:0]  LCD_CLEAR_CHAR = 8'h20;

   // Write-port controller states
   typedef enum logic [0:0] {
      SWEEP = 1'b0,
      IDLE  = 1'b1
   } lcd_state_t;

   // Identity of a requester, used to remember the last A/B winner
   typedef enum logic [0:0] {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_ram_write_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_ram_write_arbiter_if                                      |
// | Purpose  : Bundles the two requester ports, the clear/busy pair and the  |
// |            RAM write port of the LCD character-RAM write arbiter.        |
// |   master : requesters/clear source side (drives req/addr/data/clear)    |
// |   slave  : arbiter side (drives gnt_a/gnt_b/busy and the RAM port)      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface lcd_ram_write_arbiter_if
   import lcd_pkg::*;
#(
   parameter int ADDR_W = LCD_ADDR_W,
   parameter int DATA_W = LCD_DATA_W
);

   // Requester A (manual writer)
   logic              req_a;
   logic [ADDR_W-1:0] addr_a;
   logic [DATA_W-1:0] data_a;
   logic              gnt_a;

   // Requester B (message source)
   logic              req_b;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] data_b;
   logic              gnt_b;

   // Clear command and sweep status
   logic              clear;
   logic              busy;

   // RAM write port
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_we;

   modport master (
      output req_a, addr_a, data_a,
      output req_b, addr_b, data_b,
      output clear,
      input  gnt_a, gnt_b, busy,
      input  ram_waddr, ram_din, ram_we
   );

   modport slave (
      input  req_a, addr_a, data_a,
      input  req_b, addr_b, data_b,
      input  clear,
      output gnt_a, gnt_b, busy,
      output ram_waddr, ram_din, ram_we
   );

endinterface : lcd_ram_write_arbiter_if
`default_nettype wire

// File: rtl/lcd_ram_write_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb2                                                       |
// | Purpose  : Two-way round-robin picker (purely combinational).            |
// |   req[1:0]  : bit 0 = requester A, bit 1 = requester B                  |
// |   last      : requester that won the previous A/B grant                 |
// |   en        : allow a grant this cycle                                   |
// |   grant     : one-hot grant, same bit order as req                      |
// |   next_last : value of last after this cycle's decision                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arb2
   import lcd_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last,
   input  logic       en,
   output logic [1:0] grant,
   output req_id_t    next_last
);

   always_comb begin
      grant     = 2'b00;
      next_last = last;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: the side that did not win last time goes first
            2'b11:   grant = (last == REQ_B) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
      if (grant[0]) begin
         next_last = REQ_A;
      end else if (grant[1]) begin
         next_last = REQ_B;
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/lcd_ram_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_ram_write_arbiter                                         |
// | Purpose  : Write-port controller for the 32 x 8 LCD character RAM.       |
// |            Shares the single write port between requesters A and B     |
// |            (round-robin) and runs a blank-fill sweep after reset and on |
// |            a clear command. All outputs are registered.                 |
// | Ports    : CLOCK_50 - clock, rising edge                                |
// |            reset_n  - asynchronous active-low reset                     |
// |            bus      - requester, clear/busy and RAM write signals       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module lcd_ram_write_arbiter
   import lcd_pkg::*;
#(
   parameter int                ADDR_W     = LCD_ADDR_W,
   parameter int                DATA_W     = LCD_DATA_W,
   parameter logic [DATA_W-1:0] CLEAR_CHAR = LCD_CLEAR_CHAR
)(
   input  logic                     CLOCK_50,
   input  logic                     reset_n,
   lcd_ram_write_arbiter_if.slave   bus
);

   localparam logic [ADDR_W-1:0] c_last_addr  = '1;
   localparam logic [ADDR_W-1:0] c_first_next = {{(ADDR_W-1){1'b0}}, 1'b1};

   lcd_state_t        r_state;
   logic [ADDR_W-1:0] r_ptr;
   req_id_t           r_last;
   logic              r_busy;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_din;
   logic              r_gnt_a;
   logic              r_gnt_b;

   logic [1:0]        w_req;
   logic              w_en;
   logic [1:0]        w_grant;
   req_id_t           w_next_last;

   assign w_req = {bus.req_b, bus.req_a};
   // A clear command outranks any pending request in the same cycle
   assign w_en  = (r_state == IDLE) && !bus.clear;

   rr_arb2 u_rr_arb2 (
      .req       (w_req),
      .last      (r_last),
      .en        (w_en),
      .grant     (w_grant),
      .next_last (w_next_last)
   );

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= SWEEP;
         r_ptr   <= '0;
         r_last  <= REQ_B;
         r_busy  <= 1'b1;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_din   <= '0;
         r_gnt_a <= 1'b0;
         r_gnt_b <= 1'b0;
      end else begin
         r_we    <= 1'b0;
         r_gnt_a <= 1'b0;
         r_gnt_b <= 1'b0;
         case (r_state)
            SWEEP: begin
               // clear is deliberately not looked at here
               r_busy  <= 1'b1;
               r_we    <= 1'b1;
               r_waddr <= r_ptr;
               r_din   <= CLEAR_CHAR;
               if (r_ptr == c_last_addr) begin
                  r_state <= IDLE;
                  r_ptr   <= '0;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            IDLE: begin
               r_busy <= 1'b0;
               r_last <= w_next_last;
               if (bus.clear) begin
                  // Address 0 is written on the way in so the sweep's 32
                  // writes start in the very next cycle
                  r_state <= SWEEP;
                  r_busy  <= 1'b1;
                  r_we    <= 1'b1;
                  r_waddr <= '0;
                  r_din   <= CLEAR_CHAR;
                  r_ptr   <= c_first_next;
               end else if (w_grant[0]) begin
                  r_we    <= 1'b1;
                  r_waddr <= bus.addr_a;
                  r_din   <= bus.data_a;
                  r_gnt_a <= 1'b1;
               end else if (w_grant[1]) begin
                  r_we    <= 1'b1;
                  r_waddr <= bus.addr_b;
                  r_din   <= bus.data_b;
                  r_gnt_b <= 1'b1;
               end
            end
            default: begin
               r_state <= SWEEP;
               r_ptr   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.gnt_a     = r_gnt_a;
   assign bus.gnt_b     = r_gnt_b;
   assign bus.busy      = r_busy;
   assign bus.ram_we    = r_we;
   assign bus.ram_waddr = r_waddr;
   assign bus.ram_din   = r_din;

endmodule : lcd_ram_write_arbiter
`default_nettype wire

// File: tb/tb_lcd_ram_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lcd_ram_write_arbiter                                      |
// | Purpose  : Self-checking bench for lcd_ram_write_arbiter: reset sweep,   |
// |            table of single/contention vectors, clear vs request, and    |
// |            reset in the middle of a sweep.                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_lcd_ram_write_arbiter;

   logic clk;
   logic reset_n;

   lcd_ram_write_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

   lcd_ram_write_arbiter #(
      .ADDR_W     (5),
      .DATA_W     (8),
      .CLEAR_CHAR (8'h20)
   ) dut (
      .CLOCK_50 (clk),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       req_a;
      logic [4:0] addr_a;
      logic [7:0] data_a;
      logic       req_b;
      logic [4:0] addr_b;
      logic [7:0] data_b;
      logic       exp_gnt_a;
      logic       exp_gnt_b;
      logic       exp_we;
      logic [4:0] exp_waddr;
      logic [7:0] exp_din;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next active edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_sweep_write(input string tag, input int idx);
      check({tag, " ram_we"},    32'(bus.ram_we),    32'd1);
      check({tag, " ram_waddr"}, 32'(bus.ram_waddr), 32'(idx));
      check({tag, " ram_din"},   32'(bus.ram_din),   32'h20);
      check({tag, " busy"},      32'(bus.busy),      32'd1);
      check({tag, " gnt"},       32'({bus.gnt_a, bus.gnt_b}), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " ram_we"},    32'(bus.ram_we),    32'd0);
      check({tag, " gnt_a"},     32'(bus.gnt_a),     32'd0);
      check({tag, " gnt_b"},     32'(bus.gnt_b),     32'd0);
      check({tag, " ram_waddr"}, 32'(bus.ram_waddr), 32'd0);
      check({tag, " ram_din"},   32'(bus.ram_din),   32'd0);
      check({tag, " busy"},      32'(bus.busy),      32'd1);
   endtask

   initial begin
      // Single A, idle, single B, idle, six contention cycles, single A, idle
      vecs[0]  = '{1'b1, 5'h03, 8'h48, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b1, 5'h03, 8'h48};
      vecs[1]  = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'h03, 8'h48};
      vecs[2]  = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h1F, 8'h7E, 1'b0, 1'b1, 1'b1, 5'h1F, 8'h7E};
      vecs[3]  = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'h1F, 8'h7E};
      vecs[4]  = '{1'b1, 5'h01, 8'h41, 1'b1, 5'h02, 8'h42, 1'b1, 1'b0, 1'b1, 5'h01, 8'h41};
      vecs[5]  = '{1'b1, 5'h04, 8'h43, 1'b1, 5'h05, 8'h44, 1'b0, 1'b1, 1'b1, 5'h05, 8'h44};
      vecs[6]  = '{1'b1, 5'h06, 8'h45, 1'b1, 5'h07, 8'h46, 1'b1, 1'b0, 1'b1, 5'h06, 8'h45};
      vecs[7]  = '{1'b1, 5'h08, 8'h47, 1'b1, 5'h09, 8'h49, 1'b0, 1'b1, 1'b1, 5'h09, 8'h49};
      vecs[8]  = '{1'b1, 5'h0A, 8'h4A, 1'b1, 5'h0B, 8'h4B, 1'b1, 1'b0, 1'b1, 5'h0A, 8'h4A};
      vecs[9]  = '{1'b1, 5'h0C, 8'h4C, 1'b1, 5'h0D, 8'h4D, 1'b0, 1'b1, 1'b1, 5'h0D, 8'h4D};
      vecs[10] = '{1'b1, 5'h1E, 8'h61, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b1, 5'h1E, 8'h61};
      vecs[11] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'h1E, 8'h61};

      reset_n    = 1'b0;
      bus.req_a  = 1'b0;
      bus.addr_a = '0;
      bus.data_a = '0;
      bus.req_b  = 1'b0;
      bus.addr_b = '0;
      bus.data_b = '0;
      bus.clear  = 1'b0;

      // Reset state and the power-up sweep
      step();
      step();
      check_reset_values("reset");
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step();
         check_sweep_write("init_sweep", i);
      end
      step();
      check("after_init busy",   32'(bus.busy),   32'd0);
      check("after_init ram_we", 32'(bus.ram_we), 32'd0);
      check("after_init gnt",    32'({bus.gnt_a, bus.gnt_b}), 32'd0);

      // Table-driven single-requester and contention vectors
      for (int i = 0; i < 12; i++) begin
         bus.req_a  = vecs[i].req_a;
         bus.addr_a = vecs[i].addr_a;
         bus.data_a = vecs[i].data_a;
         bus.req_b  = vecs[i].req_b;
         bus.addr_b = vecs[i].addr_b;
         bus.data_b = vecs[i].data_b;
         step();
         check($sformatf("vec%0d gnt_a", i),     32'(bus.gnt_a),     32'(vecs[i].exp_gnt_a));
         check($sformatf("vec%0d gnt_b", i),     32'(bus.gnt_b),     32'(vecs[i].exp_gnt_b));
         check($sformatf("vec%0d ram_we", i),    32'(bus.ram_we),    32'(vecs[i].exp_we));
         check($sformatf("vec%0d ram_waddr", i), 32'(bus.ram_waddr), 32'(vecs[i].exp_waddr));
         check($sformatf("vec%0d ram_din", i),   32'(bus.ram_din),   32'(vecs[i].exp_din));
         check($sformatf("vec%0d busy", i),      32'(bus.busy),      32'd0);
      end
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;

      // Clear and req_b on the same edge; second clear pulse mid-sweep
      bus.clear  = 1'b1;
      bus.req_b  = 1'b1;
      bus.addr_b = 5'h0A;
      bus.data_b = 8'h55;
      step();
      bus.clear = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check_sweep_write("clr_sweep", i);
         bus.clear = (i == 9);
         step();
      end
      bus.clear = 1'b0;
      check("clr_end busy",      32'(bus.busy),      32'd0);
      check("clr_end gnt_b",     32'(bus.gnt_b),     32'd1);
      check("clr_end gnt_a",     32'(bus.gnt_a),     32'd0);
      check("clr_end ram_we",    32'(bus.ram_we),    32'd1);
      check("clr_end ram_waddr", 32'(bus.ram_waddr), 32'h0A);
      check("clr_end ram_din",   32'(bus.ram_din),   32'h55);
      bus.req_b = 1'b0;
      step();
      check("clr_post gnt_b",  32'(bus.gnt_b),  32'd0);
      check("clr_post ram_we", 32'(bus.ram_we), 32'd0);
      check("clr_post busy",   32'(bus.busy),   32'd0);

      // Reset pulsed in the middle of a sweep
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      for (int i = 0; i < 17; i++) begin
         check("mid_sweep ram_waddr", 32'(bus.ram_waddr), 32'(i));
         step();
      end
      check("mid_sweep at17 ram_waddr", 32'(bus.ram_waddr), 32'd17);
      reset_n = 1'b0;
      #2;
      check_reset_values("async_reset");
      step();
      step();
      check_reset_values("held_reset");
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step();
         check_sweep_write("restart_sweep", i);
      end
      step();
      check("restart_end busy",   32'(bus.busy),   32'd0);
      check("restart_end ram_we", 32'(bus.ram_we), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_lcd_ram_write_arbiter
`default_nettype wire
